// File: rtl/fifo_pkg.sv
// Shared types and helpers for the packet-aware store-and-forward FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;

    // Framing tags carried with every beat; the data field is appended by the
    // instantiating module because package typedefs cannot take parameters.
    typedef struct packed {
        logic sop;
        logic eop;
    } beat_tag_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Beat storage: synchronous write, asynchronous read.
module pkt_fifo_ram #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet-aware store-and-forward FIFO: packets become readable only after a clean EOP;
// errored, truncated or overflowing packets are rewound and discarded in full.
module pkt_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_sop,
    input  logic                    wr_eop,
    input  logic                    wr_err,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_sop,
    output logic                    rd_eop,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic [ptr_w(DEPTH)-1:0] pkt_count,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_MARGIN);

    typedef struct packed {
        beat_tag_t         tag;
        logic [DATA_W-1:0] data;
    } beat_t;

    wr_state_t        r_state, w_state_nxt;
    logic [PW-1:0]    r_wr_ptr, r_commit_ptr, r_rd_ptr, r_commit_tgt, r_pkt_count;
    logic             r_commit_pend, r_drop_pulse;
    logic [CNT_W-1:0] r_drop_count;

    logic [PW-1:0]    w_used, w_committed, w_commit_eff, w_wr_addr, w_wr_ptr_nxt;
    logic             w_full, w_accept, w_ovf, w_trunc, w_bad_eop, w_drop, w_wr_en, w_commit;
    logic             w_rd_valid, w_rd_fire, w_rd_eop_fire;
    beat_t            w_wr_beat, w_rd_beat;

    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_committed = r_commit_ptr - r_rd_ptr;
    assign w_full      = (w_used == DEPTH_P);
    // A commit lands one edge after its EOP; a rewind in that edge must not fall behind it.
    assign w_commit_eff = r_commit_pend ? r_commit_tgt : r_commit_ptr;
    // Beat belongs to a live packet: either continuing one or opening a new one.
    assign w_accept = wr_valid && ((r_state == WR_PKT) || wr_sop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= WR_IDLE;
        else         r_state <= w_state_nxt;
    end

    // NOTE: each always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = wr_eop ? WR_IDLE : (w_full ? WR_DROP : WR_PKT);
        else if (wr_valid && (r_state == WR_DROP) && wr_eop)
            w_state_nxt = WR_IDLE;
    end

    always_comb begin
        w_ovf        = w_accept && w_full;
        w_trunc      = w_accept && !w_full && (r_state == WR_PKT) && wr_sop;
        w_bad_eop    = w_accept && !w_full && wr_eop && wr_err;
        w_drop       = w_ovf || w_trunc || w_bad_eop;
        w_wr_en      = w_accept && !w_full && !(wr_eop && wr_err);
        w_commit     = w_wr_en && wr_eop;
        w_wr_addr    = w_drop ? w_commit_eff : r_wr_ptr;
        w_wr_ptr_nxt = w_wr_en ? (w_wr_addr + PW'(1)) : w_wr_addr;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_commit_tgt  <= '0;
            r_commit_pend <= 1'b0;
            r_pkt_count   <= '0;
            r_drop_pulse  <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_commit_pend <= w_commit;
            r_drop_pulse  <= w_drop;
            if (w_commit)      r_commit_tgt <= w_wr_ptr_nxt;
            if (r_commit_pend) r_commit_ptr <= r_commit_tgt;
            if (w_rd_fire)     r_rd_ptr     <= r_rd_ptr + PW'(1);
            if (r_commit_pend && !w_rd_eop_fire)      r_pkt_count <= r_pkt_count + PW'(1);
            else if (!r_commit_pend && w_rd_eop_fire) r_pkt_count <= r_pkt_count - PW'(1);
            if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign w_wr_beat = {wr_sop, wr_eop, wr_data};

    pkt_fifo_ram #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr[AW-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_beat)
    );

    assign w_rd_valid    = (w_committed != '0);
    assign w_rd_fire     = w_rd_valid && rd_ready;
    assign w_rd_eop_fire = w_rd_fire && w_rd_beat.tag.eop;

    assign rd_valid    = w_rd_valid;
    assign rd_data     = w_rd_valid ? w_rd_beat.data : '0;
    assign rd_sop      = w_rd_valid && w_rd_beat.tag.sop;
    assign rd_eop      = w_rd_valid && w_rd_beat.tag.eop;
    assign empty       = !w_rd_valid;
    assign full        = w_full;
    assign almost_full = ((DEPTH_P - w_used) <= AF_P);
    assign pkt_count   = r_pkt_count;
    assign drop_pulse  = r_drop_pulse;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo: directed scenarios plus randomized traffic
// compared against a packet-level queue model.
module tb_pkt_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 2;
    localparam int CNT_W     = 16;
    localparam int PW        = $clog2(DEPTH) + 1;
    localparam int OW        = DATA_W + 7 + PW + CNT_W;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              wr_valid = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, wr_err = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_ready = 1'b0;
    logic              rd_valid, rd_sop, rd_eop, full, almost_full, empty, drop_pulse;
    logic [DATA_W-1:0] rd_data;
    logic [PW-1:0]     pkt_count;
    logic [CNT_W-1:0]  drop_count;

    always #5 clk = ~clk;

    pkt_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetN(resetN),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_err(wr_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .full(full), .almost_full(almost_full), .empty(empty), .pkt_count(pkt_count),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    int total = 0;
    int bad   = 0;

    // Packet-level reference: readable beats, a packet awaiting its one-cycle commit,
    // and the packet currently being assembled.
    typedef struct { logic sop; logic eop; logic [DATA_W-1:0] data; } mbeat_t;
    mbeat_t m_cq[$];
    mbeat_t m_pq[$];
    mbeat_t m_cur[$];
    bit     m_in_pkt, m_dropping;
    int     m_drops_now = 0;
    int     m_drop_cnt  = 0;

    task automatic model_reset();
        m_cq.delete(); m_pq.delete(); m_cur.delete();
        m_in_pkt = 0; m_dropping = 0; m_drops_now = 0; m_drop_cnt = 0;
    endtask

    function automatic int m_used();
        return m_cq.size() + m_pq.size() + m_cur.size();
    endfunction

    function automatic int m_pkts();
        int n = 0;
        foreach (m_cq[i]) if (m_cq[i].eop) n++;
        return n;
    endfunction

    task automatic model_edge();
        mbeat_t moved[$];
        mbeat_t b;
        bit     full_now;
        full_now = (m_used() == DEPTH);
        moved = m_pq;
        m_pq.delete();
        m_drops_now = 0;
        if (rd_ready && m_cq.size() > 0) void'(m_cq.pop_front());
        b.sop = wr_sop; b.eop = wr_eop; b.data = wr_data;
        if (wr_valid) begin
            if (!m_in_pkt && !wr_sop) begin
                if (m_dropping && wr_eop) m_dropping = 0;
            end else if (full_now) begin
                m_drops_now++; m_cur.delete(); m_in_pkt = 0; m_dropping = !wr_eop;
            end else begin
                m_dropping = 0;
                if (m_in_pkt && wr_sop) begin m_drops_now++; m_cur.delete(); end
                if (wr_eop && wr_err) begin
                    m_drops_now++; m_cur.delete(); m_in_pkt = 0;
                end else begin
                    m_cur.push_back(b);
                    m_in_pkt = !wr_eop;
                    if (wr_eop) begin m_pq = m_cur; m_cur.delete(); end
                end
            end
        end
        foreach (moved[i]) m_cq.push_back(moved[i]);
        if (m_drops_now != 0 && m_drop_cnt < (2 ** CNT_W) - 1) m_drop_cnt++;
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, sample #1 later.
    task automatic cycle(input logic v, input logic s, input logic e, input logic er,
                         input logic [DATA_W-1:0] d, input logic rr);
        wr_valid = v; wr_sop = s; wr_eop = e; wr_err = er; wr_data = d; rd_ready = rr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [OW-1:0] dut_obs();
        return {rd_valid, rd_sop, rd_eop, rd_data, full, almost_full, empty, drop_pulse,
                pkt_count, drop_count};
    endfunction

    function automatic logic [OW-1:0] exp_obs();
        int     u;
        bit     hv;
        mbeat_t h;
        u  = m_used();
        hv = (m_cq.size() != 0);
        h.sop = 1'b0; h.eop = 1'b0; h.data = '0;
        if (hv) h = m_cq[0];
        return {hv, h.sop, h.eop, h.data, (u == DEPTH), ((DEPTH - u) <= AF_MARGIN), !hv,
                (m_drops_now != 0), PW'(m_pkts()), CNT_W'(m_drop_cnt)};
    endfunction

    task automatic test_reset();
        model_reset();
        #2;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if ({full, almost_full, drop_pulse} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {full, almost_full, drop_pulse}); end
        total++; if ({rd_data, rd_sop, rd_eop} !== '0) begin bad++; $display("FAIL reset_head: got %h/%b/%b want 0", rd_data, rd_sop, rd_eop); end
        total++; if (pkt_count !== '0 || drop_count !== '0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pkt_count, drop_count); end
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cycle(1, 1, 0, 0, 32'hA0, 0);
        cycle(1, 0, 0, 0, 32'hA1, 0);
        cycle(1, 0, 1, 0, 32'hA2, 0);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early: got %b want 0", rd_valid); end
        cycle(0, 0, 0, 0, '0, 0);
        total++; if (rd_valid !== 1'b1 || pkt_count !== PW'(1)) begin bad++; $display("FAIL basic_commit: got valid=%b cnt=%0d want 1/1", rd_valid, pkt_count); end
        total++; if (rd_data !== 32'hA0 || rd_sop !== 1'b1) begin bad++; $display("FAIL basic_beat0: got %h sop=%b want a0 sop=1", rd_data, rd_sop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (rd_data !== 32'hA1 || rd_sop !== 1'b0 || rd_eop !== 1'b0) begin bad++; $display("FAIL basic_beat1: got %h %b%b want a1 00", rd_data, rd_sop, rd_eop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (rd_data !== 32'hA2 || rd_eop !== 1'b1) begin bad++; $display("FAIL basic_beat2: got %h eop=%b want a2 eop=1", rd_data, rd_eop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (empty !== 1'b1 || pkt_count !== '0) begin bad++; $display("FAIL basic_drained: got empty=%b cnt=%0d want 1/0", empty, pkt_count); end
    endtask

    task automatic test_err_drop();
        cycle(1, 1, 0, 0, 32'hB0, 0);
        cycle(1, 0, 1, 1, 32'hB1, 0);
        total++; if (drop_pulse !== 1'b1 || drop_count !== CNT_W'(1)) begin bad++; $display("FAIL err_drop: got pulse=%b cnt=%0d want 1/1", drop_pulse, drop_count); end
        cycle(1, 1, 1, 0, 32'h55, 0);
        total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL err_pulse_width: got %b want 0", drop_pulse); end
        cycle(0, 0, 0, 0, '0, 0);
        total++; if (rd_data !== 32'h55 || rd_sop !== 1'b1 || rd_eop !== 1'b1) begin bad++; $display("FAIL err_good_pkt: got %h %b%b want 55 11", rd_data, rd_sop, rd_eop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL err_only_one: got empty=%b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 20; i++) begin
            cycle(1, (i == 1), (i == 20), 0, DATA_W'(i), 0);
            if (i <= DEPTH) begin
                total++; if (almost_full !== (i >= DEPTH - AF_MARGIN) || full !== (i == DEPTH)) begin
                    bad++; $display("FAIL ovf_flags beat=%0d: got af=%b full=%b want %b/%b", i, almost_full, full, (i >= DEPTH - AF_MARGIN), (i == DEPTH));
                end
            end else if (i == DEPTH + 1) begin
                total++; if (drop_pulse !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
                    bad++; $display("FAIL ovf_drop: got pulse=%b full=%b af=%b want 1/0/0", drop_pulse, full, almost_full);
                end
            end else begin
                total++; if (drop_pulse !== 1'b0 || full !== 1'b0) begin
                    bad++; $display("FAIL ovf_sink beat=%0d: got pulse=%b full=%b want 0/0", i, drop_pulse, full);
                end
            end
        end
        cycle(1, 1, 1, 0, 32'h77, 0);
        cycle(0, 0, 0, 0, '0, 0);
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'h77 || drop_count !== CNT_W'(2)) begin bad++; $display("FAIL ovf_next_pkt: got v=%b %h cnt=%0d want 1 77 2", rd_valid, rd_data, drop_count); end
        cycle(0, 0, 0, 0, '0, 1);
    endtask

    task automatic test_trunc();
        cycle(1, 1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 0, 32'h1, 0);
        cycle(1, 1, 0, 0, 32'h2, 0);
        total++; if (drop_pulse !== 1'b1) begin bad++; $display("FAIL trunc_pulse: got %b want 1", drop_pulse); end
        cycle(1, 0, 1, 0, 32'h3, 0);
        cycle(0, 0, 0, 0, '0, 0);
        total++; if (rd_data !== 32'h2 || rd_sop !== 1'b1) begin bad++; $display("FAIL trunc_head: got %h sop=%b want 2 sop=1", rd_data, rd_sop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (rd_data !== 32'h3 || rd_eop !== 1'b1) begin bad++; $display("FAIL trunc_tail: got %h eop=%b want 3 eop=1", rd_data, rd_eop); end
        cycle(0, 0, 0, 0, '0, 1);
        total++; if (empty !== 1'b1 || drop_count !== CNT_W'(3)) begin bad++; $display("FAIL trunc_end: got empty=%b cnt=%0d want 1/3", empty, drop_count); end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 40; c++) begin
            cycle(1, 1, 1, 0, $urandom(), 1);
            total++; if (dut_obs() !== exp_obs()) begin bad++; $display("FAIL stream_obs cyc=%0d: got %h want %h", c, dut_obs(), exp_obs()); end
            total++; if (pkt_count > PW'(2) || drop_pulse !== 1'b0) begin bad++; $display("FAIL stream_bound cyc=%0d: got cnt=%0d pulse=%b want <=2/0", c, pkt_count, drop_pulse); end
        end
        for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, '0, 1);
        total++; if (empty !== 1'b1 || pkt_count !== '0) begin bad++; $display("FAIL stream_drain: got empty=%b cnt=%0d want 1/0", empty, pkt_count); end
    endtask

    task automatic test_random();
        bit   gen_in = 0;
        logic v, s, e, er, rr;
        for (int c = 0; c < 700; c++) begin
            v  = ($urandom_range(0, 9) < 8);
            rr = (c < 350) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            s  = gen_in ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 9) < 8);
            e  = ($urandom_range(0, 5) == 0);
            er = !s && e && ($urandom_range(0, 4) == 0);
            if (v && (s || gen_in)) gen_in = !e;
            cycle(v, s, e, er, $urandom(), rr);
            total++; if (dut_obs() !== exp_obs()) begin bad++; $display("FAIL rand_obs cyc=%0d: got %h want %h", c, dut_obs(), exp_obs()); end
        end
        cycle(1, 0, 1, 1, '0, 1);
        for (int c = 0; c < 2 * DEPTH; c++) cycle(0, 0, 0, 0, '0, 1);
    endtask

    task automatic test_midreset();
        cycle(1, 1, 0, 0, 32'hC0, 0);
        cycle(1, 0, 1, 0, 32'hC1, 0);
        cycle(1, 1, 0, 0, 32'hD0, 0);
        cycle(1, 0, 0, 0, 32'hD1, 0);
        total++; if (rd_valid !== 1'b1 || rd_data !== 32'hC0) begin bad++; $display("FAIL midrst_setup: got v=%b %h want 1 c0", rd_valid, rd_data); end
        #2;
        resetN = 1'b0;
        #1;
        total++; if ({rd_valid, empty, full, almost_full, drop_pulse} !== 5'b01000) begin bad++; $display("FAIL midrst_flags: got %b want 01000", {rd_valid, empty, full, almost_full, drop_pulse}); end
        total++; if ({rd_data, rd_sop, rd_eop} !== '0 || pkt_count !== '0 || drop_count !== '0) begin bad++; $display("FAIL midrst_vals: got %h cnt=%0d drops=%0d want 0", rd_data, pkt_count, drop_count); end
        model_reset();
        wr_valid = 0; wr_sop = 0; wr_eop = 0; wr_err = 0; rd_ready = 0;
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, '0, 0);
        total++; if (drop_pulse !== 1'b0 || rd_valid !== 1'b0 || drop_count !== '0) begin bad++; $display("FAIL midrst_after: got pulse=%b v=%b drops=%0d want 0/0/0", drop_pulse, rd_valid, drop_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_drop();
        test_overflow();
        test_trunc();
        test_stream();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
